// File: rtl/intc_pkg.sv
// Shared types and helpers for the priority interrupt controller.
// Holds the request FSM state encoding, the default vector layout and the
// arithmetic vector function used by the top level.
package intc_pkg;

    // IDLE: free to arbitrate; REQ: a request is presented and frozen until ack
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } intc_state_e;

    localparam logic [31:0] INTC_VEC_BASE_DEF   = 32'h10;
    localparam logic [31:0] INTC_VEC_STRIDE_DEF = 32'd2;

    // ISR address of source `id`; the caller truncates to its vector width,
    // so the address space wraps naturally
    function automatic logic [31:0] intc_vec_f(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [31:0] id);
        return base + id * stride;
    endfunction

endpackage

// File: rtl/prio_interrupt_controller_if.sv
// CPU-side handshake bundle of the interrupt controller.
// master = controller (drives request, id, vector), slave = CPU (drives ack, ret).
interface prio_interrupt_controller_if #(
    parameter int NUM_SRC = 8,
    parameter int VEC_W   = 8
);
    localparam int ID_W = $clog2(NUM_SRC);

    logic             irq_req;
    logic             irq_ack;
    logic             irq_ret;
    logic [VEC_W-1:0] irq_vector;
    logic [ID_W-1:0]  irq_id;

    modport master (
        output irq_req,
        output irq_vector,
        output irq_id,
        input  irq_ack,
        input  irq_ret
    );

    modport slave (
        input  irq_req,
        input  irq_vector,
        input  irq_id,
        output irq_ack,
        output irq_ret
    );

endinterface

// File: rtl/intc_prio_arbiter.sv
// Combinational max-priority selector.
// Picks the requesting source with the largest priority; on a tie the lowest
// index wins because a later source must be strictly greater to replace it.
module intc_prio_arbiter
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    localparam int ID_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_cfg,
    output logic                      valid,
    output logic [ID_W-1:0]           id,
    output logic [PRIO_W-1:0]         prio
);

    // Linear scan keeping the best candidate seen so far
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // a value unassigned and no latch is inferred.
        valid = 1'b0;
        id    = '0;
        prio  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i] && (!valid || (prio_cfg[i*PRIO_W +: PRIO_W] > prio))) begin
                valid = 1'b1;
                id    = ID_W'(i);
                prio  = prio_cfg[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/prio_interrupt_controller.sv
// Priority interrupt controller: edge/level pending capture, priority
// arbitration, arithmetic vector generation and a preemption stack.
// Optional feature macro: INTC_NESTING_EN (nested preemption up to
// NEST_DEPTH levels); without it only one ISR may be active at a time.
module prio_interrupt_controller
    import intc_pkg::*;
#(
    parameter int          NUM_SRC    = 8,
    parameter int          PRIO_W     = 3,
    parameter int          VEC_W      = 8,
    parameter logic [31:0] VEC_BASE   = INTC_VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = INTC_VEC_STRIDE_DEF,
    parameter int          NEST_DEPTH = 4,
    localparam int         ID_W       = $clog2(NUM_SRC),
    localparam int         CNT_W      = $clog2(NEST_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        global_en,
    input  logic [NUM_SRC-1:0]          src,
    input  logic [NUM_SRC-1:0]          mask,
    input  logic [NUM_SRC-1:0]          edge_mode,
    input  logic [NUM_SRC*PRIO_W-1:0]   prio_cfg,
    prio_interrupt_controller_if.master cpu,
    output logic                        in_isr,
    output logic [CNT_W-1:0]            nest_level,
    output logic [NUM_SRC-1:0]          pending
);

`ifdef INTC_NESTING_EN
    localparam bit NESTING = 1'b1;
    localparam int DEPTH   = NEST_DEPTH;
`else
    localparam bit NESTING = 1'b0;
    localparam int DEPTH   = 1;
`endif
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS  = 1 << SLOT_W;

    intc_state_e       state_q, state_d;
    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [PRIO_W-1:0]  prio_q, prio_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRIO_W-1:0]  stk_prio_q [SLOTS];
    logic [PRIO_W-1:0]  stk_prio_d [SLOTS];

    logic               arb_valid;
    logic [ID_W-1:0]    arb_id;
    logic [PRIO_W-1:0]  arb_prio;

    logic [NUM_SRC-1:0] edge_rise;
    logic [NUM_SRC-1:0] ack_clr;
    logic [SLOT_W-1:0]  top_slot;
    logic [PRIO_W-1:0]  top_prio;
    logic               stack_full;
    logic               preempt_ok;
    logic               eligible;
    logic               accept;
    logic               pop;

    intc_prio_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arb (
        .req      (pending_q & mask),
        .prio_cfg (prio_cfg),
        .valid    (arb_valid),
        .id       (arb_id),
        .prio     (arb_prio)
    );

    // Handshake qualifiers and the preemption threshold from top of stack
    always_comb begin
        accept     = (state_q == REQ) && cpu.irq_ack;
        pop        = cpu.irq_ret && (cnt_q != '0);
        top_slot   = SLOT_W'(cnt_q - CNT_W'(1));
        top_prio   = stk_prio_q[top_slot];
        stack_full = cnt_q >= CNT_W'(DEPTH);
        preempt_ok = (cnt_q == '0) || (NESTING && !stack_full && (arb_prio > top_prio));
        eligible   = global_en && arb_valid && preempt_ok;
    end

    // Pending capture: edge sources latch until acked, level sources follow src
    always_comb begin
        src_d     = src;
        edge_rise = src & ~src_q;
        ack_clr   = accept ? (NUM_SRC'(1) << id_q) : '0;
        // A new edge in the ack cycle is OR-ed in after the clear, so it wins
        pending_d = (edge_mode & ((pending_q & ~ack_clr) | edge_rise))
                  | (~edge_mode & src);
    end

    // Preemption stack: pop on ret, push on ack, both together replace the top
    always_comb begin
        cnt_d      = cnt_q;
        stk_prio_d = stk_prio_q;
        if (accept && pop) begin
            stk_prio_d[top_slot] = prio_q;
        end else if (accept) begin
            stk_prio_d[SLOT_W'(cnt_q)] = prio_q;
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Request FSM: capture the winner in IDLE, freeze it in REQ until ack
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        prio_d  = prio_q;
        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d = REQ;
                    id_d    = arb_id;
                    prio_d  = arb_prio;
                    vec_d   = VEC_W'(intc_vec_f(VEC_BASE, VEC_STRIDE, 32'(arb_id)));
                end
            end
            REQ: begin
                // global_en is deliberately ignored here: the CPU must ack
                if (cpu.irq_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the stack is a handful of flops, so it is cleared with the
            // rest of the state; a RAM-based stack would only reset cnt_q.
            state_q   <= IDLE;
            src_q     <= '0;
            pending_q <= '0;
            id_q      <= '0;
            vec_q     <= '0;
            prio_q    <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                stk_prio_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            src_q      <= src_d;
            pending_q  <= pending_d;
            id_q       <= id_d;
            vec_q      <= vec_d;
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            stk_prio_q <= stk_prio_d;
        end
    end

    assign cpu.irq_req    = (state_q == REQ);
    assign cpu.irq_id     = id_q;
    assign cpu.irq_vector = vec_q;
    assign in_isr         = (cnt_q != '0);
    assign nest_level     = cnt_q;
    assign pending        = pending_q;

endmodule

// File: tb/tb_prio_interrupt_controller.sv
// Self-checking bench for prio_interrupt_controller.
// Expected (id, vector) pairs are queued when a source is raised and popped
// when the controller raises irq_req. A second instance with a wrapping
// vector layout shares the stimulus. Build with INTC_NESTING_EN to cover
// the preemption scenario instead of the single-level one.
module tb_prio_interrupt_controller;

    typedef struct {
        logic [2:0] id;
        logic [7:0] vec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        global_en;
    logic [7:0]  src;
    logic [7:0]  mask;
    logic [7:0]  edge_mode;
    logic [23:0] prio_cfg;

    logic        in_isr0, in_isr1;
    logic [2:0]  nest0, nest1;
    logic [7:0]  pend0, pend1;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    prio_interrupt_controller_if #(.NUM_SRC(8), .VEC_W(8)) cpu0();
    prio_interrupt_controller_if #(.NUM_SRC(8), .VEC_W(8)) cpu1();

    always #5 clk = ~clk;

    prio_interrupt_controller u_dut (
        .clk        (clk),
        .rst        (rst),
        .global_en  (global_en),
        .src        (src),
        .mask       (mask),
        .edge_mode  (edge_mode),
        .prio_cfg   (prio_cfg),
        .cpu        (cpu0),
        .in_isr     (in_isr0),
        .nest_level (nest0),
        .pending    (pend0)
    );

    prio_interrupt_controller #(
        .VEC_BASE   (32'hF0),
        .VEC_STRIDE (32'd4)
    ) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .global_en  (global_en),
        .src        (src),
        .mask       (mask),
        .edge_mode  (edge_mode),
        .prio_cfg   (prio_cfg),
        .cpu        (cpu1),
        .in_isr     (in_isr1),
        .nest_level (nest1),
        .pending    (pend1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id  = 3'(id);
        e.vec = 8'(32'h10 + id * 2);
        exp_q.push_back(e);
    endtask

    // Waits up to max cycles for irq_req, then compares against the scoreboard
    task automatic expect_req(input string tag, input int max, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (cpu0.irq_req !== 1'b1 && lat < max) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_req"}, 32'(cpu0.irq_req), 32'd1);
        if (cpu0.irq_req === 1'b1) begin
            if (exp_lat >= 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL %s_sb: got=request exp=no request", tag);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_id"},  32'(cpu0.irq_id),     32'(e.id));
                check({tag, "_vec"}, 32'(cpu0.irq_vector), 32'(e.vec));
            end
        end
    endtask

    task automatic pulse(input logic ack, input logic ret);
        cpu0.irq_ack = ack;
        cpu0.irq_ret = ret;
        @(negedge clk);
        cpu0.irq_ack = 1'b0;
        cpu0.irq_ret = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [2:0] prio_tab [8];
        prio_tab = '{3'd4, 3'd2, 3'd1, 3'd5, 3'd6, 3'd6, 3'd2, 3'd3};

        rst          = 1'b1;
        global_en    = 1'b1;
        src          = '0;
        mask         = 8'hFF;
        edge_mode    = 8'hFE;   // src0 level, all others edge
        for (int i = 0; i < 8; i++) prio_cfg[i*3 +: 3] = prio_tab[i];
        cpu0.irq_ack = 1'b0;
        cpu0.irq_ret = 1'b0;
        cpu1.irq_ack = 1'b0;
        cpu1.irq_ret = 1'b0;

        idle(2);
        check("rst_req",     32'(cpu0.irq_req),    32'd0);
        check("rst_vec",     32'(cpu0.irq_vector), 32'd0);
        check("rst_id",      32'(cpu0.irq_id),     32'd0);
        check("rst_nest",    32'(nest0),           32'd0);
        check("rst_in_isr",  32'(in_isr0),         32'd0);
        check("rst_pending", 32'(pend0),           32'd0);
        rst = 1'b0;
        idle(1);

        // 1: single edge source, 2-cycle latency, ack clears pending
        src[3] = 1'b1;
        push_exp(3);
        expect_req("t1", 6, 2);
        check("t1_pend_set", 32'(pend0[3]), 32'd1);
        src[3] = 1'b0;
        pulse(1'b1, 1'b0);
        check("t1_req_drop", 32'(cpu0.irq_req), 32'd0);
        check("t1_pend_clr", 32'(pend0[3]),     32'd0);
        check("t1_in_isr",   32'(in_isr0),      32'd1);
        check("t1_nest",     32'(nest0),        32'd1);
        pulse(1'b1, 1'b0);   // ack without a request
        check("t1_stray_ack", 32'(nest0), 32'd1);
        pulse(1'b0, 1'b1);
        check("t1_ret_nest",  32'(nest0),   32'd0);
        check("t1_ret_isr",   32'(in_isr0), 32'd0);
        pulse(1'b0, 1'b1);   // ret with empty stack
        check("t1_empty_ret", 32'(nest0),   32'd0);

        // 2: equal priorities, lowest index first
        src[1] = 1'b1;
        src[6] = 1'b1;
        push_exp(1);
        push_exp(6);
        expect_req("t2a", 6, 2);
        src[1] = 1'b0;
        src[6] = 1'b0;
        pulse(1'b1, 1'b0);
        check("t2_pend6", 32'(pend0[6]), 32'd1);
        pulse(1'b0, 1'b1);
        expect_req("t2b", 6, -1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("t2_pend_all", 32'(pend0), 32'd0);

        // 3: level source survives ack, re-requests after ret, drops with src
        src[0] = 1'b1;
        push_exp(0);
        expect_req("t3a", 6, 2);
        pulse(1'b1, 1'b0);
        idle(3);
        check("t3_hold_req",  32'(cpu0.irq_req), 32'd0);
        check("t3_hold_pend", 32'(pend0[0]),     32'd1);
        push_exp(0);
        pulse(1'b0, 1'b1);
        expect_req("t3b", 6, -1);
        pulse(1'b1, 1'b0);
        src[0] = 1'b0;
        pulse(1'b0, 1'b1);
        idle(2);
        check("t3_drop_pend", 32'(pend0[0]),     32'd0);
        check("t3_drop_req",  32'(cpu0.irq_req), 32'd0);
        check("t3_drop_nest", 32'(nest0),        32'd0);

        // 4/5: higher-priority source arrives during a low-priority ISR
        src[2] = 1'b1;
        push_exp(2);
        expect_req("t4a", 6, 2);
        src[2] = 1'b0;
        pulse(1'b1, 1'b0);
        src[5] = 1'b1;
`ifdef INTC_NESTING_EN
        push_exp(5);
        expect_req("t4b", 6, 2);
        src[5] = 1'b0;
        pulse(1'b1, 1'b0);
        check("t4_nest2", 32'(nest0), 32'd2);
        src[4] = 1'b1;
        idle(4);
        check("t4_no_preempt", 32'(cpu0.irq_req), 32'd0);
        check("t4_pend4",      32'(pend0[4]),     32'd1);
        src[4] = 1'b0;
        push_exp(4);
        pulse(1'b0, 1'b1);
        expect_req("t4c", 6, -1);
        pulse(1'b1, 1'b1);   // ret and ack together: pop then push
        check("t4_ret_ack", 32'(nest0), 32'd1);
        pulse(1'b0, 1'b1);
        check("t4_nest0", 32'(nest0), 32'd0);
`else
        idle(4);
        check("t5_block_req", 32'(cpu0.irq_req), 32'd0);
        check("t5_pend5",     32'(pend0[5]),     32'd1);
        src[5] = 1'b0;
        push_exp(5);
        pulse(1'b0, 1'b1);
        expect_req("t5b", 6, -1);
        pulse(1'b1, 1'b0);
        check("t5_nest1", 32'(nest0), 32'd1);
        pulse(1'b0, 1'b1);
        check("t5_nest0", 32'(nest0), 32'd0);
`endif

        // 6: wrapped vector, global_en drop held in REQ, reset in REQ
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        src[7] = 1'b1;
        push_exp(7);
        expect_req("t6", 6, 2);
        check("t6_wrap_req", 32'(cpu1.irq_req),    32'd1);
        check("t6_wrap_id",  32'(cpu1.irq_id),     32'd7);
        check("t6_wrap_vec", 32'(cpu1.irq_vector), 32'h0C);
        global_en = 1'b0;
        idle(2);
        check("t6_gen_hold", 32'(cpu0.irq_req), 32'd1);
        rst = 1'b1;
        idle(1);
        check("t6_rst_req",  32'(cpu0.irq_req), 32'd0);
        check("t6_rst_req1", 32'(cpu1.irq_req), 32'd0);
        check("t6_rst_pend", 32'(pend0),        32'd0);
        check("t6_rst_wrap", 32'({nest1, pend1}), 32'd0);
        rst       = 1'b0;
        global_en = 1'b1;
        src       = '0;
        idle(2);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
